// File: rtl/mem_pkg.sv
// Shared constants for the unified-memory subsystem: geometry, arbiter
// state/owner encodings and the instruction fields used by the CPU and benches.
package mem_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   // Instruction fields shared with the CPU decoder and test tasks
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_JMP   = 4'h7;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [2:0] CC_ALWAYS = 3'd0;
   localparam logic [2:0] CC_EQ     = 3'd1;
   localparam logic [2:0] CC_NE     = 3'd2;
   localparam logic [2:0] CC_LT     = 3'd3;
   localparam logic [2:0] CC_GE     = 3'd4;

   localparam logic [2:0] REG_R0 = 3'd0;
   localparam logic [2:0] REG_R1 = 3'd1;
   localparam logic [2:0] REG_R2 = 3'd2;
   localparam logic [2:0] REG_R3 = 3'd3;
   localparam logic [2:0] REG_SP = 3'd6;
   localparam logic [2:0] REG_PC = 3'd7;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not own the
// last slot wins.
module rr_pick2 (
   input  logic elig_cpu,
   input  logic elig_dma,
   input  logic last_owner,
   output logic valid,
   output logic winner
);
   import mem_pkg::*;

   always_comb begin
      valid = elig_cpu | elig_dma;
      if (elig_cpu && elig_dma)
         winner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
      else
         winner = elig_dma ? OWN_DMA : OWN_CPU;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port unified memory between CPU and DMA: one-cycle memory
// slot (ACC) followed by a registered acknowledge cycle (RESP).
module mem_arbiter #(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_in_data,
   input  logic [DATA_W-1:0] mem_out_data,
   output logic              owner,
   output logic              busy
);
   import mem_pkg::*;

   arb_state_t        state, state_d;
   logic              mem_write_d, cpu_ack_d, dma_ack_d, owner_d, busy_d;
   logic [ADDR_W-1:0] mem_address_d;
   logic [DATA_W-1:0] mem_in_data_d, cpu_rdata_d, dma_rdata_d;
   logic              pick_valid, pick_winner;

   // A requester whose ack is high still shows the req of the access just served
   rr_pick2 u_pick (
      .elig_cpu   (cpu_req & ~cpu_ack),
      .elig_dma   (dma_req & ~dma_ack),
      .last_owner (owner),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_in_data <= '0;
         cpu_ack     <= 1'b0;
         dma_ack     <= 1'b0;
         cpu_rdata   <= '0;
         dma_rdata   <= '0;
         busy        <= 1'b0;
         owner       <= OWN_DMA;
      end else begin
         state       <= state_d;
         mem_write   <= mem_write_d;
         mem_address <= mem_address_d;
         mem_in_data <= mem_in_data_d;
         cpu_ack     <= cpu_ack_d;
         dma_ack     <= dma_ack_d;
         cpu_rdata   <= cpu_rdata_d;
         dma_rdata   <= dma_rdata_d;
         busy        <= busy_d;
         owner       <= owner_d;
      end
   end

   always_comb begin
      state_d       = state;
      mem_write_d   = 1'b0;
      mem_address_d = mem_address;
      mem_in_data_d = mem_in_data;
      cpu_ack_d     = 1'b0;
      dma_ack_d     = 1'b0;
      cpu_rdata_d   = cpu_rdata;
      dma_rdata_d   = dma_rdata;
      busy_d        = 1'b0;
      owner_d       = owner;
      case (state)
         ACC: begin
            if (owner == OWN_CPU) begin
               cpu_ack_d   = 1'b1;
               cpu_rdata_d = mem_out_data;
            end else begin
               dma_ack_d   = 1'b1;
               dma_rdata_d = mem_out_data;
            end
            state_d = RESP;
         end
         default: begin
            if (pick_valid) begin
               owner_d = pick_winner;
               busy_d  = 1'b1;
               state_d = ACC;
               if (pick_winner == OWN_CPU) begin
                  mem_address_d = cpu_addr;
                  mem_in_data_d = cpu_wdata;
                  mem_write_d   = cpu_we;
               end else begin
                  mem_address_d = dma_addr;
                  mem_in_data_d = dma_wdata;
                  mem_write_d   = dma_we;
               end
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 4096x32
// memory (negedge write, asynchronous read).
module tb_mem_arbiter;
   import mem_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [11:0] cpu_addr, dma_addr;
   logic [31:0] cpu_wdata, dma_wdata;
   logic        cpu_ack, dma_ack, mem_write, owner, busy;
   logic [31:0] cpu_rdata, dma_rdata, mem_in_data, mem_out_data;
   logic [11:0] mem_address;

   logic [31:0] mem [0:4095];
   int n_cmp = 0;
   int n_err = 0;

   mem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_write(mem_write), .mem_address(mem_address), .mem_in_data(mem_in_data),
      .mem_out_data(mem_out_data), .owner(owner), .busy(busy)
   );

   always #5 clock = ~clock;

   assign mem_out_data = mem[mem_address];
   always @(negedge clock) if (mem_write) mem[mem_address] <= mem_in_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int acks, ci, di, last_c, idx;
      int order[$];
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      for (int i = 0; i < 4; i++) mem[i] = 32'h100 + i;
      mem[5]  = 32'd6;
      mem[10] = 32'd11;
      reset_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
      #12;
      chk("rst_mem_write", mem_write, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_in_data", mem_in_data, 0);
      chk("rst_acks", {cpu_ack, dma_ack}, 0);
      chk("rst_rdata", cpu_rdata | dma_rdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, OWN_DMA);
      reset_n = 1'b1;
      tick();

      // 1: CPU read of address 5
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'd5;
      tick();
      chk("t1_acc_addr", mem_address, 5);
      chk("t1_acc_busy", busy, 1);
      chk("t1_acc_owner", owner, OWN_CPU);
      chk("t1_acc_nowrite", mem_write, 0);
      chk("t1_acc_noack", cpu_ack, 0);
      tick();
      chk("t1_cpu_ack", cpu_ack, 1);
      chk("t1_cpu_rdata", cpu_rdata, 6);
      chk("t1_dma_ack", dma_ack, 0);
      chk("t1_resp_busy", busy, 0);
      cpu_req = 0;
      tick();
      chk("t1_ack_drop", cpu_ack, 0);

      // 2: DMA write to 4061, then CPU reads it back (granted straight from RESP)
      dma_req = 1; dma_we = 1; dma_addr = 12'd4061; dma_wdata = 32'hDEADBEEF;
      tick();
      chk("t2_write_hi", mem_write, 1);
      chk("t2_owner", owner, OWN_DMA);
      chk("t2_addr", mem_address, 4061);
      chk("t2_in_data", mem_in_data, 32'hDEADBEEF);
      tick();
      chk("t2_write_lo", mem_write, 0);
      chk("t2_dma_ack", dma_ack, 1);
      chk("t2_dma_rdata", dma_rdata, 32'hDEADBEEF);
      dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 12'd4061;
      tick();
      chk("t2_cpu_acc_busy", busy, 1);
      chk("t2_cpu_owner", owner, OWN_CPU);
      chk("t2_cpu_addr", mem_address, 4061);
      tick();
      chk("t2_cpu_ack", cpu_ack, 1);
      chk("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      cpu_req = 0;
      tick();

      // 4: CPU alone, held requesting, three reads
      acks = 0; idx = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'd0;
      for (int c = 0; c < 14; c++) begin
         tick();
         chk("t4_no_dma_ack", dma_ack, 0);
         if (cpu_ack) begin
            acks++;
            chk("t4_rdata", cpu_rdata, 32'h100 + idx);
            idx++;
            if (idx < 3) cpu_addr = 12'(idx);
            else cpu_req = 0;
         end
      end
      chk("t4_ack_count", acks, 3);

      // 5: reset during ACC of a DMA write to address 10
      dma_req = 1; dma_we = 1; dma_addr = 12'd10; dma_wdata = 32'h55;
      tick();
      chk("t5_acc_write", mem_write, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("t5_write_drop", mem_write, 0);
      chk("t5_addr", mem_address, 0);
      chk("t5_in_data", mem_in_data, 0);
      chk("t5_acks", {cpu_ack, dma_ack}, 0);
      chk("t5_busy", busy, 0);
      chk("t5_owner", owner, OWN_DMA);
      dma_req = 0;
      #10;
      chk("t5_mem10", mem[10], 11);
      reset_n = 1'b1;
      acks = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         acks += int'(dma_ack);
      end
      chk("t5_no_ack", acks, 0);

      // 3: both requesting continuously; grants must alternate starting with CPU
      ci = 0; di = 0; last_c = -1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'd0;
      dma_req = 1; dma_we = 1; dma_addr = 12'd100; dma_wdata = 32'hA0000000;
      for (int c = 0; c < 24 && (ci < 4 || di < 4); c++) begin
         tick();
         if (cpu_ack || dma_ack) begin
            if (last_c >= 0) chk("t3_ack_gap", c - last_c, 2);
            last_c = c;
         end
         if (cpu_ack) begin
            chk("t3_cpu_rdata", cpu_rdata, 32'h100 + ci);
            order.push_back(0);
            ci++;
            if (ci < 4) cpu_addr = 12'(ci);
            else cpu_req = 0;
         end
         if (dma_ack) begin
            chk("t3_dma_rdata", dma_rdata, 32'hA0000000 + di);
            order.push_back(1);
            di++;
            if (di < 4) begin
               dma_addr = 12'(100 + di);
               dma_wdata = 32'hA0000000 + di;
            end else dma_req = 0;
         end
      end
      chk("t3_cpu_count", ci, 4);
      chk("t3_dma_count", di, 4);
      chk("t3_order_len", order.size(), 8);
      for (int k = 0; k < order.size(); k++) chk("t3_order", order[k], k % 2);
      for (int k = 0; k < 4; k++) chk("t3_mem_wr", mem[100 + k], 32'hA0000000 + k);
      tick();

      // 6: DMA request arriving as the CPU RESP ends is granted directly
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'd2;
      tick();
      tick();
      chk("t6_cpu_ack", cpu_ack, 1);
      chk("t6_cpu_rdata", cpu_rdata, 32'h102);
      cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 12'd100;
      tick();
      chk("t6_direct_busy", busy, 1);
      chk("t6_direct_owner", owner, OWN_DMA);
      chk("t6_direct_addr", mem_address, 100);
      chk("t6_cpu_ack_clr", cpu_ack, 0);
      tick();
      chk("t6_dma_ack", dma_ack, 1);
      chk("t6_dma_rdata", dma_rdata, 32'hA0000000);
      dma_req = 0;
      tick();
      chk("t6_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
